// File: rtl/hamming_pkg.sv
// Shared Hamming code geometry helpers used by the encoder pipeline and the matching decoder.
package hamming_pkg;

  localparam int MAX_DATA_W = 57;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--) begin
      if ((1 << k) >= data_w + k + 1) p = k;
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Hamming position of data bit j: the (j+1)-th non-power-of-2 position.
  function automatic int data_pos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 3; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == j && res == 0) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic int code_w(input int data_w, input int secded);
    return data_w + calc_p(data_w) + secded;
  endfunction

endpackage

// File: rtl/hamming_parity_calc.sv
// Combinational Hamming parity generator: data word in, P even-parity check bits out.
module hamming_parity_calc
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 4,
  localparam int P      = calc_p(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [P-1:0]      parity
);

  // Data bits whose Hamming position has bit i set feed check bit i.
  function automatic logic [DATA_W-1:0] cover_mask(input int i);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (((data_pos(j) >> i) & 1) != 0) m[j] = 1'b1;
    end
    return m;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < P; gi = gi + 1) begin : g_par
      localparam logic [DATA_W-1:0] COVER = cover_mask(gi);
      assign parity[gi] = ^(data & COVER);
    end
  endgenerate

endmodule

// File: rtl/hamming_secded_enc_pipe.sv
// Two-stage valid/ready Hamming (SEC or SECDED) encoder with per-beat error injection
// and an emitted-word counter.
module hamming_secded_enc_pipe
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 4,
  parameter int  SECDED = 1,
  parameter int  CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int HAM_W  = DATA_W + P,
  localparam int CODE_W = code_w(DATA_W, SECDED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CODE_W-1:0] in_inj_mask,
  input  logic              inj_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_injected,
  output logic [CNT_W-1:0]  word_count,
  input  logic              clr_count
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [P-1:0]      s1_parity;
  logic [CODE_W-1:0] s1_mask;
  logic [P-1:0]      parity_next;
  logic [HAM_W-1:0]  ham;
  logic [CODE_W-1:0] clean_code;
  logic              s2_free;
  logic              s1_move;
  logic              in_fire;

  // A stage may load when empty or when its occupant leaves this cycle.
  assign s2_free  = !out_valid || out_ready;
  assign s1_move  = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_move;
  assign in_fire  = in_valid && in_ready;

  hamming_parity_calc #(
    .DATA_W(DATA_W)
  ) u_parity (
    .data  (in_data),
    .parity(parity_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_parity <= '0;
      s1_mask   <= '0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_data   <= in_data;
      s1_parity <= parity_next;
      s1_mask   <= inj_en ? in_inj_mask : '0;
    end else if (s1_move) begin
      s1_valid  <= 1'b0;
    end
  end

  // Position k lands on ham[k-1]; data index = k - 1 - (number of powers of 2 below k+1).
  genvar gi;
  generate
    for (gi = 1; gi <= HAM_W; gi = gi + 1) begin : g_pos
      if (is_pow2(gi)) begin : g_chk
        assign ham[gi-1] = s1_parity[$clog2(gi)];
      end else begin : g_dat
        assign ham[gi-1] = s1_data[gi - 1 - $clog2(gi + 1)];
      end
    end

    if (SECDED != 0) begin : g_secded
      assign clean_code = {^ham, ham};
    end else begin : g_sec
      assign clean_code = ham;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_code     <= '0;
      out_injected <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_code     <= clean_code ^ s1_mask;
        out_injected <= |s1_mask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (clr_count) begin
      word_count <= '0;
    end else if (out_valid && out_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/hamming_secded_enc_pipe.md
Name: hamming_secded_enc_pipe

Overview:
Parametrised, pipelined Hamming encoder with optional SECDED extension. It carries each data word through a two-stage valid/ready stream and can inject test errors per beat. It is the streaming successor to the combinational (7,4) encoder, and with DATA_W=4, SECDED=0 it produces the identical 7-bit codeword layout. It sits between a data producer and the channel/memory model, feeding the matching decoder in the correction datapath.

Parameters:
DATA_W, 4, data bits per word; legal values 1..57.
SECDED, 1, 1 appends the overall-parity bit, 0 gives plain Hamming SEC.
CNT_W, 16, width of the emitted-word counter.
Derived constants (not overridable):
- P = smallest integer with 2^P >= DATA_W+P+1.
- CODE_W = DATA_W+P+SECDED.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  DATA_W  data word
in_inj_mask  in  CODE_W  error-injection mask, travels with the beat
inj_en  in  1  global injection enable, sampled with the beat
out_valid  out  1  codeword valid
out_ready  in  1  downstream accepts
out_code  out  CODE_W  codeword
out_injected  out  1  beat carried a nonzero applied mask
word_count  out  CNT_W  count of output handshakes
clr_count  in  1  synchronous counter clear

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst is high, out_valid=0, out_code=0, out_injected=0, word_count=0 and all stage valids=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation discards every in-flight beat; there is no partial output.
- Position map, Hamming positions 1..DATA_W+P:
  - Parity bit i sits at position 2^i.
  - Data bits fill the non-power-of-2 positions in ascending order, with in_data[0] at the lowest.
  - out_code[k-1] = position k.
  - If SECDED=1, out_code[CODE_W-1] = XOR of all Hamming positions (even overall parity).
- Parity: bit at 2^i = XOR of all data positions whose index has bit i set (even parity).
- Stage 1:
  - On an in_valid && in_ready handshake, register the data, the P parity bits, and mask = inj_en ? in_inj_mask : 0.
- Stage 2:
  - Assemble the codeword and compute overall parity over the clean codeword.
  - out_code = clean codeword XOR mask.
  - out_injected = |mask.
- Latency: exactly 2 cycles from input handshake to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Backpressure:
  - Each stage loads when it is empty or its content is leaving this cycle.
  - in_ready = !s1_valid || (s1 moving to s2).
  - in_ready is combinational from out_ready; it has no combinational path from in_valid.
  - out_code and out_valid are stable while out_valid && !out_ready. At most 2 beats are held.
- Ordering: strictly in-order, with no drops or duplicates.
- word_count:
  - Increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
  - clr_count has priority over a same-cycle increment; the result is 0.
- Simultaneous input and output handshakes in one cycle are legal and must not stall.

Decomposition:
- A shared package hamming_pkg holds:
  - a function for P from DATA_W;
  - a function is_pow2(pos);
  - a function data_pos(j) giving the Hamming position of data bit j;
  - CODE_W computation.
  The decoder reuses the same package.
- One sub-module, hamming_parity_calc: combinational, parametrised on DATA_W, mapping data to P parity bits. Stage 1 instantiates it.

Test Plan:
1. DATA_W=4, SECDED=0, out_ready=1:
   - in_data=4'b1011 -> out_code=7'h55, two cycles later.
   - 4'b1111 -> 7'h7F.
   - 4'b0000 -> 7'h00.
2. DATA_W=4, SECDED=1:
   - 4'b1011 -> 8'h55.
   - 4'b1111 -> 8'hFF.
   - The 16-value sweep matches the golden model, and every output has even weight.
3. inj_en=1, mask=8'h04 on 4'b1011 -> out_code=8'h51, out_injected=1. The next beat has inj_en=0 with the same mask -> 8'h55, out_injected=0.
4. Backpressure:
   - Stream 5 beats with out_ready=0 -> in_ready drops after 2 accepted beats and out_code holds.
   - Release out_ready -> all 5 beats arrive in order and word_count=5.
5. Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 immediately, word_count=0, no stale beat after release.
6. DATA_W=26, SECDED=1 (CODE_W=32), random 1000 beats with random out_ready -> every codeword matches the model. Assert clr_count on the same cycle as a handshake -> word_count=0.
